// File: rtl/cpu_stage_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module : cpu_seq_pkg
// Brief  : State encodings, parameter defaults and one-hot helper for the sequencer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_seq_pkg;

  localparam logic [1:0] c_ST_IDLE     = 2'b00;
  localparam logic [1:0] c_ST_STEP     = 2'b01;
  localparam logic [1:0] c_ST_MEM_WAIT = 2'b10;
  localparam logic [1:0] c_ST_HALT     = 2'b11;

  localparam int DEF_NUM_STAGES  = 5;
  localparam int DEF_MEM_STAGE   = 3;
  localparam int DEF_MEM_TIMEOUT = 15;
  localparam int DEF_IDX_W       = 4;
  localparam int c_MAX_STAGES    = 16;

  // Callers cast the result down to their own stage count.
  function automatic logic [c_MAX_STAGES-1:0] onehot_from_idx(input logic [3:0] idx);
    return c_MAX_STAGES'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_stage_sequencer_if.sv
//------------------------------------------------------------------------------
// Module : cpu_stage_sequencer_if
// Brief  : Control/strobe/memory-handshake bundle between sequencer and datapath.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface cpu_stage_sequencer_if
  import cpu_seq_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int IDX_W      = DEF_IDX_W
);
  logic                  run;
  logic                  halt_req;
  logic                  mem_access;
  logic                  mem_ready;
  logic [NUM_STAGES-1:0] stage_go;
  logic [IDX_W-1:0]      stage_idx;
  logic                  mem_req;
  logic                  instr_retired;
  logic [31:0]           retire_count;
  logic                  busy;
  logic                  halted;
  logic                  mem_err;

  modport master (
    input  run, halt_req, mem_access, mem_ready,
    output stage_go, stage_idx, mem_req, instr_retired, retire_count, busy, halted, mem_err
  );

  modport slave (
    output run, halt_req, mem_access, mem_ready,
    input  stage_go, stage_idx, mem_req, instr_retired, retire_count, busy, halted, mem_err
  );
endinterface

`default_nettype wire

// File: rtl/cpu_stage_sequencer_timeout_ctr.sv
//------------------------------------------------------------------------------
// Module : seq_timeout_ctr
// Brief  : Saturating wait counter with clear/enable; o_term flags LIMIT-1 reached.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_timeout_ctr #(
  parameter int LIMIT = 15
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clr,
  input  wire logic i_en,
  output logic      o_term
);
  localparam int            c_cnt_w = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [c_cnt_w-1:0] c_term = c_cnt_w'(LIMIT - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != c_term)) begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  assign o_term = (r_cnt == c_term);
endmodule

`default_nettype wire

// File: rtl/cpu_stage_sequencer.sv
//------------------------------------------------------------------------------
// Module : cpu_stage_sequencer
// Brief  : Multicycle stage sequencer with memory-stage skip/stall, timeout and
//          run/halt control. SEQ_DEBUG_PORT_EN adds the dbg_state output.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cpu_stage_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int MEM_STAGE   = DEF_MEM_STAGE,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int IDX_W       = DEF_IDX_W
) (
  input  wire logic             clk,
  input  wire logic             nreset,
`ifdef SEQ_DEBUG_PORT_EN
  output logic [7:0]            dbg_state,
`endif
  cpu_stage_sequencer_if.master bus
);
  localparam logic [IDX_W-1:0] c_last_idx     = IDX_W'(NUM_STAGES - 1);
  localparam logic [IDX_W-1:0] c_pre_mem_idx  = IDX_W'(MEM_STAGE - 1);
  localparam logic [IDX_W-1:0] c_mem_idx      = IDX_W'(MEM_STAGE);
  localparam logic [IDX_W-1:0] c_post_mem_idx = IDX_W'(MEM_STAGE + 1);

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_next_idx;
  logic                  r_halt_pending;
  logic                  w_next_halt_pending;
  logic                  w_timeout;
  logic                  w_to_term;

  logic [NUM_STAGES-1:0] r_stage_go,      w_stage_go;
  logic                  r_mem_req,       w_mem_req;
  logic                  r_instr_retired, w_instr_retired;
  logic [31:0]           r_retire_count,  w_retire_count;
  logic                  r_busy,          w_busy;
  logic                  r_halted,        w_halted;
  logic                  r_mem_err,       w_mem_err;

  seq_timeout_ctr #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst    (nreset),
    .i_clr  (r_state != c_ST_MEM_WAIT),
    .i_en   ((r_state == c_ST_MEM_WAIT) && !bus.mem_ready),
    .o_term (w_to_term)
  );

  assign w_next_halt_pending = r_halt_pending | bus.halt_req;

  always_ff @(posedge clk) begin
    if (nreset) begin
      r_state         <= c_ST_IDLE;
      r_idx           <= '0;
      r_halt_pending  <= 1'b0;
      r_stage_go      <= '0;
      r_mem_req       <= 1'b0;
      r_instr_retired <= 1'b0;
      r_retire_count  <= '0;
      r_busy          <= 1'b0;
      r_halted        <= 1'b0;
      r_mem_err       <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_idx           <= w_next_idx;
      r_halt_pending  <= w_next_halt_pending;
      r_stage_go      <= w_stage_go;
      r_mem_req       <= w_mem_req;
      r_instr_retired <= w_instr_retired;
      r_retire_count  <= w_retire_count;
      r_busy          <= w_busy;
      r_halted        <= w_halted;
      r_mem_err       <= w_mem_err;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_timeout    = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        w_next_idx = '0;
        if (r_halt_pending) begin
          w_next_state = c_ST_HALT;
        end else if (bus.run) begin
          w_next_state = c_ST_STEP;
        end
      end
      c_ST_STEP: begin
        if (r_idx == c_last_idx) begin
          // Retire boundary: halt beats run, and a same-cycle halt_req counts.
          w_next_idx = '0;
          if (w_next_halt_pending) begin
            w_next_state = c_ST_HALT;
          end else if (!bus.run) begin
            w_next_state = c_ST_IDLE;
          end
        end else if (r_idx == c_pre_mem_idx) begin
          if (bus.mem_access) begin
            w_next_state = c_ST_MEM_WAIT;
            w_next_idx   = c_mem_idx;
          end else begin
            w_next_idx   = c_post_mem_idx;
          end
        end else begin
          w_next_idx = r_idx + IDX_W'(1);
        end
      end
      c_ST_MEM_WAIT: begin
        if (bus.mem_ready) begin
          w_next_state = c_ST_STEP;
        end else if (w_to_term) begin
          w_next_state = c_ST_HALT;
          w_next_idx   = '0;
          w_timeout    = 1'b1;
        end
      end
      c_ST_HALT: begin
        w_next_idx = '0;
      end
      default: begin
        w_next_state = c_ST_IDLE;
        w_next_idx   = '0;
      end
    endcase
  end

  always_comb begin
    w_stage_go = '0;
    if (w_next_state == c_ST_STEP) begin
      w_stage_go = NUM_STAGES'(onehot_from_idx(4'(w_next_idx)));
    end
    w_mem_req       = (w_next_state == c_ST_MEM_WAIT);
    w_busy          = (w_next_state == c_ST_STEP) || (w_next_state == c_ST_MEM_WAIT);
    w_halted        = (w_next_state == c_ST_HALT);
    w_instr_retired = (w_next_state == c_ST_STEP) && (w_next_idx == c_last_idx);
    w_retire_count  = r_retire_count + {31'd0, w_instr_retired};
    w_mem_err       = r_mem_err | w_timeout;
  end

  assign bus.stage_go      = r_stage_go;
  assign bus.stage_idx     = r_idx;
  assign bus.mem_req       = r_mem_req;
  assign bus.instr_retired = r_instr_retired;
  assign bus.retire_count  = r_retire_count;
  assign bus.busy          = r_busy;
  assign bus.halted        = r_halted;
  assign bus.mem_err       = r_mem_err;

`ifdef SEQ_DEBUG_PORT_EN
  logic [7:0] r_dbg_state;

  always_ff @(posedge clk) begin
    if (nreset) begin
      r_dbg_state <= '0;
    end else begin
      r_dbg_state <= {w_next_state, w_mem_err, w_next_halt_pending, 4'(w_next_idx)};
    end
  end

  assign dbg_state = r_dbg_state;
`endif
endmodule

`default_nettype wire

// File: tb/tb_cpu_stage_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_cpu_stage_sequencer
// Brief  : Directed vector table plus hand sequences for cpu_stage_sequencer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_stage_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_stage_sequencer_if #(.NUM_STAGES(5), .IDX_W(4)) bus_a ();
  cpu_stage_sequencer_if #(.NUM_STAGES(7), .IDX_W(4)) bus_b ();

`ifdef SEQ_DEBUG_PORT_EN
  logic [7:0] dbg_a, dbg_b;
`endif

  cpu_stage_sequencer #(.NUM_STAGES(5), .MEM_STAGE(3), .MEM_TIMEOUT(15), .IDX_W(4)) dut_a (
    .clk    (clk),
    .nreset (rst),
`ifdef SEQ_DEBUG_PORT_EN
    .dbg_state (dbg_a),
`endif
    .bus    (bus_a.master)
  );

  cpu_stage_sequencer #(.NUM_STAGES(7), .MEM_STAGE(2), .MEM_TIMEOUT(15), .IDX_W(4)) dut_b (
    .clk    (clk),
    .nreset (rst),
`ifdef SEQ_DEBUG_PORT_EN
    .dbg_state (dbg_b),
`endif
    .bus    (bus_b.master)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step_a(input logic run, input logic hr, input logic ma, input logic mr);
    @(negedge clk);
    bus_a.run = run; bus_a.halt_req = hr; bus_a.mem_access = ma; bus_a.mem_ready = mr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string t, input logic [4:0] go, input logic [3:0] idx,
                       input logic req, input logic ret, input logic busy,
                       input logic hlt, input logic err, input logic [31:0] cnt);
    chk({t, "_go"},   32'(bus_a.stage_go),      32'(go));
    chk({t, "_idx"},  32'(bus_a.stage_idx),     32'(idx));
    chk({t, "_req"},  32'(bus_a.mem_req),       32'(req));
    chk({t, "_ret"},  32'(bus_a.instr_retired), 32'(ret));
    chk({t, "_busy"}, 32'(bus_a.busy),          32'(busy));
    chk({t, "_hlt"},  32'(bus_a.halted),        32'(hlt));
    chk({t, "_err"},  32'(bus_a.mem_err),       32'(err));
    chk({t, "_cnt"},  bus_a.retire_count,       cnt);
  endtask

  task automatic reset_all();
    rst = 1'b1;
    step_a(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        run, hr, ma, mr;
    logic [4:0]  go;
    logic [3:0]  idx;
    logic        req, ret, busy, hlt, err;
    logic [31:0] cnt;
  } vec_t;

  vec_t vt [18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int parity, last_c, nret;
    int exp_len [4];
    bus_a.run = 0; bus_a.halt_req = 0; bus_a.mem_access = 0; bus_a.mem_ready = 0;
    bus_b.run = 0; bus_b.halt_req = 0; bus_b.mem_access = 0; bus_b.mem_ready = 0;

    // run, hr, ma, mr | go, idx, req, ret, busy, hlt, err, cnt
    vt[0]  = '{1'b1,1'b0,1'b0,1'b0, 5'b00001, 4'd0, 1'b0,1'b0,1'b1,1'b0,1'b0, 32'd0};
    vt[1]  = '{1'b1,1'b0,1'b0,1'b0, 5'b00010, 4'd1, 1'b0,1'b0,1'b1,1'b0,1'b0, 32'd0};
    vt[2]  = '{1'b1,1'b0,1'b0,1'b0, 5'b00100, 4'd2, 1'b0,1'b0,1'b1,1'b0,1'b0, 32'd0};
    vt[3]  = '{1'b1,1'b0,1'b0,1'b0, 5'b10000, 4'd4, 1'b0,1'b1,1'b1,1'b0,1'b0, 32'd1};
    vt[4]  = '{1'b1,1'b0,1'b0,1'b0, 5'b00001, 4'd0, 1'b0,1'b0,1'b1,1'b0,1'b0, 32'd1};
    vt[5]  = '{1'b1,1'b0,1'b0,1'b0, 5'b00010, 4'd1, 1'b0,1'b0,1'b1,1'b0,1'b0, 32'd1};
    vt[6]  = '{1'b1,1'b0,1'b0,1'b0, 5'b00100, 4'd2, 1'b0,1'b0,1'b1,1'b0,1'b0, 32'd1};
    vt[7]  = '{1'b0,1'b0,1'b0,1'b0, 5'b10000, 4'd4, 1'b0,1'b1,1'b1,1'b0,1'b0, 32'd2};
    vt[8]  = '{1'b0,1'b0,1'b0,1'b0, 5'b00000, 4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'd2};
    vt[9]  = '{1'b1,1'b0,1'b1,1'b1, 5'b00001, 4'd0, 1'b0,1'b0,1'b1,1'b0,1'b0, 32'd2};
    vt[10] = '{1'b1,1'b0,1'b1,1'b1, 5'b00010, 4'd1, 1'b0,1'b0,1'b1,1'b0,1'b0, 32'd2};
    vt[11] = '{1'b1,1'b0,1'b1,1'b1, 5'b00100, 4'd2, 1'b0,1'b0,1'b1,1'b0,1'b0, 32'd2};
    vt[12] = '{1'b1,1'b0,1'b1,1'b0, 5'b00000, 4'd3, 1'b1,1'b0,1'b1,1'b0,1'b0, 32'd2};
    vt[13] = '{1'b1,1'b0,1'b0,1'b0, 5'b00000, 4'd3, 1'b1,1'b0,1'b1,1'b0,1'b0, 32'd2};
    vt[14] = '{1'b1,1'b0,1'b0,1'b0, 5'b00000, 4'd3, 1'b1,1'b0,1'b1,1'b0,1'b0, 32'd2};
    vt[15] = '{1'b1,1'b0,1'b0,1'b1, 5'b01000, 4'd3, 1'b0,1'b0,1'b1,1'b0,1'b0, 32'd2};
    vt[16] = '{1'b0,1'b0,1'b0,1'b0, 5'b10000, 4'd4, 1'b0,1'b1,1'b1,1'b0,1'b0, 32'd3};
    vt[17] = '{1'b0,1'b0,1'b0,1'b0, 5'b00000, 4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'd3};

    rst = 1'b1;
    step_a(1'b1, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 1'b0, 1'b0, 1'b0);
    chk_a("reset", 5'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      step_a(vt[i].run, vt[i].hr, vt[i].ma, vt[i].mr);
      chk_a($sformatf("v%0d", i), vt[i].go, vt[i].idx, vt[i].req, vt[i].ret,
            vt[i].busy, vt[i].hlt, vt[i].err, vt[i].cnt);
    end

    // Memory timeout: 15 wait cycles without ready, then HALT with mem_err.
    repeat (3) step_a(1'b1, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (14) step_a(1'b1, 1'b0, 1'b0, 1'b0);
    chk_a("to_wait15", 5'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3);
    step_a(1'b1, 1'b0, 1'b0, 1'b0);
    chk_a("to_err", 5'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd3);
    repeat (3) step_a(1'b1, 1'b0, 1'b0, 1'b1);
    chk_a("to_stuck", 5'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd3);

    // Ready on the terminal-count cycle wins over the timeout.
    reset_all();
    chk_a("rst2", 5'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (3) step_a(1'b1, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (14) step_a(1'b1, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 1'b0, 1'b0, 1'b1);
    chk_a("term_ready", 5'b01000, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step_a(1'b0, 1'b0, 1'b0, 1'b0);
    chk_a("term_retire", 5'b10000, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1);

    // halt_req pulsed in stage 1: instruction retires, then HALT forever.
    reset_all();
    step_a(1'b1, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 1'b1, 1'b0, 1'b0);
    step_a(1'b1, 1'b0, 1'b0, 1'b0);
    chk_a("halt_retire", 5'b10000, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1);
    step_a(1'b1, 1'b0, 1'b0, 1'b0);
    chk_a("halt_enter", 5'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1);
    repeat (4) step_a(1'b1, 1'b0, 1'b0, 1'b0);
    chk_a("halt_hold", 5'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1);

    // Reset in MEM_WAIT after one retired instruction.
    reset_all();
    repeat (7) step_a(1'b1, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 1'b0, 1'b1, 1'b0);
    chk_a("mw_pre", 5'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1);
    rst = 1'b1;
    step_a(1'b1, 1'b0, 1'b0, 1'b1);
    chk_a("mw_rst", 5'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    step_a(1'b0, 1'b0, 1'b0, 1'b1);
    chk_a("mw_idle", 5'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    // 7 stages, memory at 2: alternating 6/8-cycle instructions, counter wrap.
    @(negedge clk);
    force dut_b.r_retire_count = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut_b.r_retire_count;
    @(posedge clk); #1;
    chk("b_preload", bus_b.retire_count, 32'hFFFF_FFFF);
    exp_len = '{6, 8, 6, 8};
    parity = 0; last_c = 0; nret = 0;
    for (int c = 1; c <= 80 && nret < 4; c++) begin
      @(negedge clk);
      bus_b.run = 1'b1; bus_b.mem_access = parity[0]; bus_b.mem_ready = 1'b1;
      @(posedge clk); #1;
      if (bus_b.instr_retired) begin
        chk($sformatf("b_len%0d", nret), 32'(c - last_c), 32'(exp_len[nret]));
        chk($sformatf("b_cnt%0d", nret), bus_b.retire_count, 32'(nret));
        last_c = c; nret++; parity = 1 - parity;
      end
    end
    chk("b_retires", 32'(nret), 32'd4);
    @(negedge clk);
    bus_b.run = 1'b0;
    @(posedge clk); #1;
    chk("b_idle_busy", 32'(bus_b.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_stage_sequencer.md
Name: cpu_stage_sequencer

Overview:
Parametrised multicycle control sequencer for the ARM datapath. It replaces the fixed five-state go-pulse FSM.
- Emits one-hot stage_go strobes over a configurable number of stages.
- Skips the data-memory stage for non-memory instructions.
- Stalls on a data-memory req/ready handshake, with a timeout.
- Supports run/halt control and counts retired instructions.

Parameters:
NUM_STAGES, 5, number of pipeline-step strobes per instruction; legal range 3..16.
MEM_STAGE, 3, index of the data-memory stage; 0 < MEM_STAGE < NUM_STAGES-1.
MEM_TIMEOUT, 15, maximum cycles in MEM_WAIT without mem_ready before error; must be >= 1.
IDX_W, 4, width of stage_idx; must be >= clog2(NUM_STAGES).

Ports:
clk  in  1  single system clock, rising edge.
nreset  in  1  synchronous, active-high reset (high = reset).
run  in  1  level; 1 = sequence instructions, 0 = stop at next retire boundary.
halt_req  in  1  pulse or level; captured sticky, honoured at the next retire boundary.
mem_access  in  1  current instruction needs data memory; sampled when leaving stage MEM_STAGE-1.
mem_ready  in  1  data memory done/accepted; valid only while mem_req=1.
stage_go  out  NUM_STAGES  registered one-hot strobe; bit i = stage i active this cycle.
stage_idx  out  IDX_W  index of the current or pending stage.
mem_req  out  1  registered; high throughout MEM_WAIT.
instr_retired  out  1  one-cycle pulse coincident with stage_go[NUM_STAGES-1].
retire_count  out  32  retired-instruction counter; wraps modulo 2^32.
busy  out  1  1 in STEP or MEM_WAIT.
halted  out  1  1 in HALT.
mem_err  out  1  sticky; set on memory timeout.

Behaviour:
- States: IDLE, STEP, MEM_WAIT, HALT. All outputs are registered.
- Reset (nreset=1 at posedge): state=IDLE. All outputs are cleared: stage_go=0, stage_idx=0, mem_req=0, instr_retired=0, retire_count=0, busy=0, halted=0, mem_err=0. halt_pending=0 and timeout count=0.
- Reset takes effect mid-instruction, including in MEM_WAIT: mem_req drops the next cycle and there is no retire.
- IDLE -> STEP:
  - When run=1 at cycle N, stage_go[0]=1 at N+1.
  - If halt_pending=1 in IDLE, go to HALT instead.
- STEP, stage_idx advances by 1 each cycle:
  - From MEM_STAGE-1 with mem_access=0: jump to MEM_STAGE+1. stage_go[MEM_STAGE] never asserts. An instruction takes NUM_STAGES-1 cycles.
  - From MEM_STAGE-1 with mem_access=1: enter MEM_WAIT. stage_go=0, mem_req=1.
- MEM_WAIT:
  - When mem_ready=1 is sampled: next cycle mem_req=0, stage_go[MEM_STAGE]=1, state=STEP. Minimum total is NUM_STAGES+1 cycles per instruction.
  - The timeout counter increments each MEM_WAIT cycle without ready.
  - On reaching MEM_TIMEOUT: mem_err=1, mem_req=0, state=HALT.
  - mem_ready on the same cycle as the terminal count: ready wins, no error.
- Retire (stage_go[NUM_STAGES-1]=1): instr_retired=1 and retire_count increments in the same cycle. The next state is:
  - HALT if halt_pending=1 or halt_req=1 (halt wins over run);
  - else IDLE if run=0;
  - else stage 0 on the next cycle, with no gap.
- halt_req: sampled every cycle into sticky halt_pending. It never aborts an in-flight instruction.
- HALT: stage_go=0, busy=0, halted=1. Exits only via reset.
- run deasserted mid-instruction: the current instruction completes, then IDLE.
- mem_ready outside MEM_WAIT is ignored.

Optional Feature:
Macro SEQ_DEBUG_PORT_EN.
- Defined: adds output dbg_state (8 bits), registered = {state[1:0], mem_err, halt_pending, stage_idx[3:0]}, for mapping onto a debug_port. Its reset value is 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package cpu_seq_pkg holds:
  - the state encoding constants (IDLE=2'b00, STEP=2'b01, MEM_WAIT=2'b10, HALT=2'b11);
  - default values for NUM_STAGES, MEM_STAGE and MEM_TIMEOUT;
  - a one-hot-from-index function.
- One sub-module, seq_timeout_ctr: saturating counter with clear and enable that outputs a terminal flag; used for MEM_WAIT.

Test Plan:
- Reset then run=1 with mem_access=0 (defaults): stage_go = 00001, 00010, 00100, 10000, then 00001 again. instr_retired pulses on the 4th strobe; retire_count goes 0->1->2.
- mem_access=1 with mem_ready high 3 cycles after mem_req rises: mem_req is high 3 cycles, stage_go[3] follows one cycle after ready, and the instruction takes 8 cycles.
- mem_access=1 with mem_ready never asserted, MEM_TIMEOUT=15: after 15 MEM_WAIT cycles mem_err=1, halted=1, mem_req=0. retire_count is unchanged.
- halt_req pulsed during stage 1: the instruction completes and retires, then halted=1 and stage_go stays 0. run=1 has no further effect until reset.
- nreset asserted during MEM_WAIT: the next cycle shows all outputs 0 and state IDLE. retire_count=0 and mem_err=0.
- NUM_STAGES=7, MEM_STAGE=2, mem_access alternating 0/1 with ready immediate: instructions alternate 6 and 8 cycles. retire_count wraps from 32'hFFFFFFFF to 0 when preloaded via a forced test.
